// File: rtl/mac_rx_frame_if.sv
// RMII receive-side bundle: PHY dibit stream in, captured payload and its valid pulse out.
// master = stream source / payload consumer, slave = the mac_rx_frame receiver.
interface mac_rx_frame_if #(
    parameter int PAYLOAD_BYTES = 5
) ();
    logic                       crsdv;
    logic [1:0]                 rxd;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic                       valid;

    modport master (output crsdv, output rxd, input payload, input valid);
    modport slave  (input crsdv, input rxd, output payload, output valid);
endinterface

// File: rtl/mac_rx_frame.sv
// RMII receive front end: preamble strip, MAC/ethertype filter, payload capture and FCS check.
// Optional frame statistics counters are compiled in when MAC_RX_STATS_EN is defined.
module mac_rx_frame #(
    parameter logic [47:0] FPGA_MAC         = 48'h12_34_56_78_9A_BC,
    parameter logic [15:0] ETHERTYPE        = 16'h88B5,
    parameter int          PAYLOAD_BYTES    = 5,
    parameter bit          ACCEPT_BROADCAST = 1'b0,
    parameter int          MAX_FRAME_BYTES  = 1522
) (
    input  logic          clk,
    input  logic          rst,
    mac_rx_frame_if.slave rx,
    output logic [2:0]    state_dbg
`ifdef MAC_RX_STATS_EN
    ,
    output logic [15:0]   frames_ok,
    output logic [15:0]   frames_crc_err,
    output logic [15:0]   frames_filtered
`endif
);
    localparam int              CW          = $clog2(MAX_FRAME_BYTES + 1);
    localparam int              PW          = 8 * PAYLOAD_BYTES;
    localparam logic [CW-1:0]   MAX_CNT     = CW'(MAX_FRAME_BYTES);
    localparam logic [CW-1:0]   MIN_CNT     = CW'(18 + PAYLOAD_BYTES);
    localparam logic [CW-1:0]   LAST_PAY    = CW'(13 + PAYLOAD_BYTES);
    localparam logic [31:0]     CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]     CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_TAIL, S_DROP
    } state_t;

    // valid/payload contract: valid is high for exactly one cycle per accepted
    // frame and payload changes only on that cycle; there is no back-pressure.

    state_t          state, state_d;
    logic [1:0]      phase;
    logic [5:0]      sr;
    logic [CW-1:0]   byte_cnt;
    logic [31:0]     crc;
    logic [PW-1:0]   shadow, shadow_sh, payload_q;
    logic            valid_q, mac_hit, bc_hit;

    logic            clr_frame, take_dibit, byte_done, shift_pay, accept;
    logic            mac_hit_d, bc_hit_d, filt_evt, crc_evt;
    logic [7:0]      byte_val, mac_byte;
    logic [2:0]      hdr_sel;
    logic [47:0]     mac_shift;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_DROP;
        else     state <= state_d;
    end

    always_comb begin
        state_d    = state;
        clr_frame  = 1'b0;
        take_dibit = 1'b0;
        shift_pay  = 1'b0;
        accept     = 1'b0;
        filt_evt   = 1'b0;
        crc_evt    = 1'b0;
        mac_hit_d  = mac_hit;
        bc_hit_d   = bc_hit;
        byte_val   = {rx.rxd, sr};
        byte_done  = (phase == 2'd3);
        hdr_sel    = 3'd5 - byte_cnt[2:0];
        mac_shift  = FPGA_MAC >> {hdr_sel, 3'b000};
        mac_byte   = mac_shift[7:0];
        shadow_sh  = shadow << 8;
        shadow_sh[7:0] = byte_val;

        case (state)
            S_IDLE: begin
                if (rx.crsdv) begin
                    if (rx.rxd == 2'b01)      state_d = S_PREAMBLE;
                    else if (rx.rxd != 2'b00) state_d = S_DROP;
                end
            end
            S_PREAMBLE: begin
                if (!rx.crsdv) state_d = S_IDLE;
                else if (rx.rxd == 2'b11) begin
                    state_d   = S_HEADER;
                    clr_frame = 1'b1;
                end else if (rx.rxd != 2'b01) state_d = S_DROP;
            end
            S_HEADER, S_PAYLOAD, S_TAIL: begin
                if (!rx.crsdv) begin
                    state_d = S_IDLE;
                    if (state == S_TAIL && phase == 2'd0 && byte_cnt >= MIN_CNT) begin
                        if (crc == CRC_RESIDUE) accept  = 1'b1;
                        else                    crc_evt = 1'b1;
                    end
                end else begin
                    take_dibit = 1'b1;
                    if (byte_done) begin
                        if (byte_cnt == MAX_CNT) begin
                            state_d  = S_DROP;
                            filt_evt = 1'b1;
                        end else if (state == S_HEADER) begin
                            if (byte_cnt < CW'(6)) begin
                                mac_hit_d = mac_hit && (byte_val == mac_byte);
                                bc_hit_d  = bc_hit && (byte_val == 8'hFF);
                                if (!mac_hit_d && !bc_hit_d) begin
                                    state_d  = S_DROP;
                                    filt_evt = 1'b1;
                                end
                            end else if (byte_cnt == CW'(12) && byte_val != ETHERTYPE[15:8]) begin
                                state_d  = S_DROP;
                                filt_evt = 1'b1;
                            end else if (byte_cnt == CW'(13)) begin
                                if (byte_val != ETHERTYPE[7:0]) begin
                                    state_d  = S_DROP;
                                    filt_evt = 1'b1;
                                end else state_d = S_PAYLOAD;
                            end
                        end else if (state == S_PAYLOAD) begin
                            shift_pay = 1'b1;
                            if (byte_cnt == LAST_PAY) state_d = S_TAIL;
                        end
                    end
                end
            end
            S_DROP: begin
                if (!rx.crsdv) state_d = S_IDLE;
            end
            default: state_d = S_DROP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= '0;
            sr        <= '0;
            byte_cnt  <= '0;
            crc       <= '0;
            shadow    <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            mac_hit   <= 1'b0;
            bc_hit    <= 1'b0;
        end else begin
            valid_q <= accept;
            if (accept) payload_q <= shadow;
            if (clr_frame) begin
                phase    <= '0;
                byte_cnt <= '0;
                crc      <= 32'hFFFF_FFFF;
                mac_hit  <= 1'b1;
                bc_hit   <= ACCEPT_BROADCAST;
            end else if (take_dibit) begin
                phase   <= phase + 2'd1;
                sr      <= {rx.rxd, sr[5:2]};
                crc     <= crc_dibit(crc, rx.rxd);
                mac_hit <= mac_hit_d;
                bc_hit  <= bc_hit_d;
                if (byte_done) byte_cnt <= byte_cnt + CW'(1);
                if (shift_pay) shadow <= shadow_sh;
            end
        end
    end

`ifdef MAC_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_ok       <= '0;
            frames_crc_err  <= '0;
            frames_filtered <= '0;
        end else begin
            if (accept && frames_ok != 16'hFFFF)         frames_ok       <= frames_ok + 16'd1;
            if (crc_evt && frames_crc_err != 16'hFFFF)   frames_crc_err  <= frames_crc_err + 16'd1;
            if (filt_evt && frames_filtered != 16'hFFFF) frames_filtered <= frames_filtered + 16'd1;
        end
    end
`endif

    assign rx.payload = payload_q;
    assign rx.valid   = valid_q;
    assign state_dbg  = state;
endmodule
